// File: rtl/button_event_ctrl_if.sv
// Button event bus: raw button/enable in, debounced level, event pulses and FSM state out.
// master = the controller, slave = the consumer that drives the button and takes the events.
interface button_event_ctrl_if;
   logic       btn_in;
   logic       enable;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic [2:0] state_o;

   modport master (
      input  btn_in, enable,
      output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, state_o
   );

   modport slave (
      output btn_in, enable,
      input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse, state_o
   );
endinterface

// File: rtl/button_event_ctrl.sv
// Turns a raw bouncing push-button into clean single-cycle press/release/long/repeat events.
// Chain: synchroniser -> debounce FSM with shared counter -> registered pulses.
module button_event_ctrl #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DEBOUNCE_CYC = 20,
   parameter int unsigned LONG_CYC     = 100,
   parameter int unsigned REPEAT_CYC   = 25,
   parameter int unsigned CNT_W        = 16
) (
   input logic                  clk,
   input logic                  reset_n,
   button_event_ctrl_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DB_PRESS = 3'd1,
      HELD     = 3'd2,
      REPEAT   = 3'd3,
      DB_REL   = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_s;
   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   long_done_q;
   logic                   level_q;
   logic                   press_q;
   logic                   release_q;
   logic                   long_q;
   logic                   repeat_q;

   // Metastability synchroniser for the asynchronous button
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
   end

   assign btn_s = sync_q[SYNC_STAGES-1];

   // Debounce / hold FSM; cnt_q is shared by all timed states and cleared on each entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         repeat_q    <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (btn_s && bus.enable) begin
                  state_q <= DB_PRESS;
                  cnt_q   <= '0;
               end
            end
            DB_PRESS: begin
               if (!btn_s || !bus.enable) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_q     <= HELD;
                  cnt_q       <= '0;
                  level_q     <= 1'b1;
                  press_q     <= 1'b1;
                  long_done_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            HELD: begin
               // A falling button wins over a terminating long count
               if (!btn_s) begin
                  state_q <= DB_REL;
                  cnt_q   <= '0;
               end else if (cnt_q == LONG_LAST) begin
                  state_q     <= REPEAT;
                  cnt_q       <= '0;
                  long_q      <= bus.enable;
                  long_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (!btn_s) begin
                  state_q <= DB_REL;
                  cnt_q   <= '0;
               end else if (cnt_q == REP_LAST) begin
                  cnt_q    <= '0;
                  repeat_q <= bus.enable;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DB_REL: begin
               if (btn_s) begin
                  state_q <= long_done_q ? REPEAT : HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_q   <= IDLE;
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.btn_level     = level_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.long_pulse    = long_q;
   assign bus.repeat_pulse  = repeat_q;
   assign bus.state_o       = state_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: run-length reference model checked every cycle,
// directed scenarios pinned to hand-computed edge numbers, then random bouncing stimulus.
module tb_button_event_ctrl;

   localparam int SYNC_STAGES  = 2;
   localparam int DEBOUNCE_CYC = 4;
   localparam int LONG_CYC     = 10;
   localparam int REPEAT_CYC   = 3;
   localparam int CNT_W        = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   bit   chk_on = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   ecnt = 0;

   button_event_ctrl_if bus ();

   button_event_ctrl #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .CNT_W       (CNT_W)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Reference model: acceptance is a run of identical synchronised samples,
   // hold timing is a count of high samples since the press or since a rejected release glitch.
   logic [SYNC_STAGES-1:0] m_sh = '0;
   bit   m_pressed = 1'b0, m_long_done = 1'b0;
   int   m_press_run = 0, m_zero_run = 0, m_hold = 0;
   logic e_level = 1'b0, e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0, e_rep = 1'b0;
   logic [2:0] e_state = 3'd0;
   int   ev_press[$], ev_rel[$], ev_long[$], ev_rep[$];

   task automatic model_reset();
      m_sh = '0; m_pressed = 1'b0; m_long_done = 1'b0;
      m_press_run = 0; m_zero_run = 0; m_hold = 0;
      e_level = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
      e_state = 3'd0;
   endtask

   task automatic model_step(input logic s, input logic en, input logic raw);
      e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
      if (!m_pressed) begin
         m_press_run = (s && en) ? m_press_run + 1 : 0;
         if (m_press_run == DEBOUNCE_CYC + 1) begin
            m_pressed = 1'b1; m_long_done = 1'b0; m_hold = 0; m_press_run = 0;
            e_press = 1'b1; e_level = 1'b1;
         end
      end else if (!s) begin
         m_hold = 0;
         m_zero_run++;
         if (m_zero_run == DEBOUNCE_CYC + 1) begin
            m_pressed = 1'b0; m_zero_run = 0;
            e_rel = 1'b1; e_level = 1'b0;
         end
      end else if (m_zero_run != 0) begin
         m_zero_run = 0; m_hold = 0;
      end else begin
         m_hold++;
         if (!m_long_done && m_hold == LONG_CYC) begin
            e_long = en; m_long_done = 1'b1; m_hold = 0;
         end else if (m_long_done && m_hold == REPEAT_CYC) begin
            e_rep = en; m_hold = 0;
         end
      end
      m_sh = {m_sh[SYNC_STAGES-2:0], raw};
      if (!m_pressed)          e_state = (m_press_run > 0) ? 3'd1 : 3'd0;
      else if (m_zero_run > 0) e_state = 3'd4;
      else                     e_state = m_long_done ? 3'd3 : 3'd2;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         ecnt++;
         model_step(m_sh[SYNC_STAGES-1], bus.enable, bus.btn_in);
         if (e_press) ev_press.push_back(ecnt);
         if (e_rel)   ev_rel.push_back(ecnt);
         if (e_long)  ev_long.push_back(ecnt);
         if (e_rep)   ev_rep.push_back(ecnt);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("btn_level",     32'(bus.btn_level),     32'(e_level));
         check("press_pulse",   32'(bus.press_pulse),   32'(e_press));
         check("release_pulse", 32'(bus.release_pulse), 32'(e_rel));
         check("long_pulse",    32'(bus.long_pulse),    32'(e_long));
         check("repeat_pulse",  32'(bus.repeat_pulse),  32'(e_rep));
         check("state_o",       32'(bus.state_o),       32'(e_state));
         check("pulse_onehot",  32'(int'(bus.press_pulse) + int'(bus.release_pulse) +
                                    int'(bus.long_pulse) + int'(bus.repeat_pulse) > 1), 32'(0));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_ev();
      ev_press.delete(); ev_rel.delete(); ev_long.delete(); ev_rep.delete();
   endtask

   task automatic settle();
      bus.btn_in = 1'b0;
      cyc(15);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_level"},   32'(bus.btn_level),     32'(0));
      check({tag, "_press"},   32'(bus.press_pulse),   32'(0));
      check({tag, "_release"}, 32'(bus.release_pulse), 32'(0));
      check({tag, "_long"},    32'(bus.long_pulse),    32'(0));
      check({tag, "_repeat"},  32'(bus.repeat_pulse),  32'(0));
      check({tag, "_state"},   32'(bus.state_o),       32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.btn_in = 1'b0;
      bus.enable = 1'b1;
      cyc(3);
      check_outputs_zero("reset");
      chk_on = 1'b1;
      reset_n = 1'b1;
      cyc(5);

      // 1: clean hold for 30 edges
      clear_ev(); base = ecnt; bus.btn_in = 1'b1;
      cyc(30); bus.btn_in = 1'b0; cyc(20);
      check("s1_press_n", 32'(ev_press.size()), 32'(1));
      if (ev_press.size() > 0) check("s1_press_edge", 32'(ev_press[0] - base), 32'(7));
      check("s1_long_n", 32'(ev_long.size()), 32'(1));
      if (ev_long.size() > 0) check("s1_long_edge", 32'(ev_long[0] - base), 32'(17));
      check("s1_rep_n", 32'(ev_rep.size()), 32'(5));
      for (int i = 0; i < 5; i++)
         if (ev_rep.size() > i) check("s1_rep_edge", 32'(ev_rep[i] - base), 32'(20 + 3 * i));
      check("s1_rel_n", 32'(ev_rel.size()), 32'(1));
      if (ev_rel.size() > 0) check("s1_rel_edge", 32'(ev_rel[0] - base), 32'(37));
      settle();

      // 2: short bounce is rejected
      clear_ev(); bus.btn_in = 1'b1; cyc(3); bus.btn_in = 1'b0; cyc(15);
      check("s2_events", 32'(ev_press.size() + ev_rel.size()), 32'(0));
      check("s2_level", 32'(bus.btn_level), 32'(0));
      check("s2_state", 32'(bus.state_o), 32'(0));

      // 3: two-cycle release glitch while HELD
      clear_ev(); base = ecnt; bus.btn_in = 1'b1;
      cyc(12); bus.btn_in = 1'b0; cyc(2); bus.btn_in = 1'b1;
      cyc(1); check("s3_in_dbrel", 32'(bus.state_o), 32'(4));
      cyc(2); check("s3_back_held", 32'(bus.state_o), 32'(2));
      check("s3_level", 32'(bus.btn_level), 32'(1));
      cyc(20);
      check("s3_no_rel", 32'(ev_rel.size()), 32'(0));
      check("s3_long_n", 32'(ev_long.size()), 32'(1));
      if (ev_long.size() > 0) check("s3_long_edge", 32'(ev_long[0] - base), 32'(27));
      settle();
      check("s3_rel_n", 32'(ev_rel.size()), 32'(1));
      settle();

      // 4: enable gating
      clear_ev(); bus.enable = 1'b0; bus.btn_in = 1'b1; cyc(20);
      check("s4_blocked_state", 32'(bus.state_o), 32'(0));
      settle();
      bus.enable = 1'b1; bus.btn_in = 1'b1; cyc(4);
      check("s4_dbpress", 32'(bus.state_o), 32'(1));
      bus.enable = 1'b0; cyc(1);
      check("s4_abort", 32'(bus.state_o), 32'(0));
      cyc(10); settle();
      check("s4_no_press", 32'(ev_press.size()), 32'(0));
      bus.enable = 1'b1; bus.btn_in = 1'b1; cyc(9);
      bus.enable = 1'b0; cyc(21); bus.btn_in = 1'b0; cyc(15);
      check("s4_press_n", 32'(ev_press.size()), 32'(1));
      check("s4_long_masked", 32'(ev_long.size() + ev_rep.size()), 32'(0));
      check("s4_rel_n", 32'(ev_rel.size()), 32'(1));
      bus.enable = 1'b1; settle();

      // 5: reset while in REPEAT
      clear_ev(); bus.btn_in = 1'b1; cyc(22);
      check("s5_in_repeat", 32'(bus.state_o), 32'(3));
      #2 reset_n = 1'b0;
      #1 check_outputs_zero("s5_async");
      bus.btn_in = 1'b0; cyc(2); reset_n = 1'b1; cyc(20);
      check("s5_no_rel", 32'(ev_rel.size()), 32'(0));
      check("s5_level", 32'(bus.btn_level), 32'(0));

      // 6: button drops on the sample where the long count terminates
      clear_ev(); base = ecnt; bus.btn_in = 1'b1; cyc(14); bus.btn_in = 1'b0; cyc(20);
      check("s6_no_long", 32'(ev_long.size()), 32'(0));
      check("s6_rel_n", 32'(ev_rel.size()), 32'(1));
      if (ev_rel.size() > 0) check("s6_rel_edge", 32'(ev_rel[0] - base), 32'(21));
      settle();

      // Random bouncing segments with occasional enable toggles and resets
      for (int seg = 0; seg < 300; seg++) begin
         bus.btn_in = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 7) == 0) bus.enable = ~bus.enable;
         if ($urandom_range(0, 99) == 0) begin
            #2 reset_n = 1'b0;
            #2 reset_n = 1'b1;
         end
         cyc($urandom_range(1, (seg % 3 == 0) ? 40 : 6));
      end
      settle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
